// File: rtl/axi_lite_reg_selftest_if.sv
// AXI4-Lite bus bundle between the register self-test master and the slave register bank.
// The master modport drives address/data/VALID and the response READYs; the slave modport mirrors it.
interface axi_lite_reg_selftest_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_reg_selftest.sv
// AXI4-Lite master that writes a pattern to each slave register, reads it back and reports errors.
// Define SELFTEST_TIMEOUT_EN to enable the per-transaction watchdog; otherwise the FSM waits forever.
module axi_lite_reg_selftest #(
    parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned                   NUM_REGS           = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_STRIDE        = 4,
    parameter logic [31:0]                   SEED               = 32'h0101FFFF,
    parameter logic [31:0]                   PAT_INC            = 32'h00000001,
    parameter int unsigned                   TIMEOUT_CYCLES     = 256
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [7:0]               err_count,
    output logic [7:0]               first_err_idx,
    output logic                     timeout,
    axi_lite_reg_selftest_if.master  m_axi
);
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
    localparam logic [DW-1:0] PAT_SEED = DW'(SEED);
    localparam logic [DW-1:0] PAT_STEP = DW'(PAT_INC);
    localparam logic [7:0]    LAST_IDX = 8'(NUM_REGS - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_WB   = 3'd2;
    localparam logic [2:0] S_RA   = 3'd3;
    localparam logic [2:0] S_RD   = 3'd4;
    localparam logic [2:0] S_NEXT = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    if (NUM_REGS < 1 || NUM_REGS > 256 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("axi_lite_reg_selftest: NUM_REGS must be 1..256 and TIMEOUT_CYCLES at least 1");
    end

    logic [2:0]                    state;
    logic [2:0]                    state_next;
    logic [7:0]                    idx;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
    logic [DW-1:0]                 pattern;
    logic                          aw_valid;
    logic                          w_valid;
    logic                          aw_ok;
    logic                          w_ok;
    logic                          aw_fire;
    logic                          w_fire;
    logic                          wr_done;
    logic                          b_fire;
    logic                          ar_fire;
    logic                          r_fire;
    logic                          b_bad;
    logic                          r_bad;
    logic                          log_err;
    logic                          start_accept;
    logic                          tmo_abort;

    assign aw_fire      = aw_valid && m_axi.awready;
    assign w_fire       = w_valid && m_axi.wready;
    assign wr_done      = (state == S_WR) && (aw_ok || aw_fire) && (w_ok || w_fire);
    assign b_fire       = (state == S_WB) && m_axi.bvalid;
    assign ar_fire      = (state == S_RA) && m_axi.arready;
    assign r_fire       = (state == S_RD) && m_axi.rvalid;
    assign b_bad        = (m_axi.bresp != 2'b00);
    assign r_bad        = (m_axi.rresp != 2'b00) || (m_axi.rdata != pattern);
    assign start_accept = (state == S_IDLE) && start;
    // A register with both a bad response and a data mismatch is one error
    assign log_err      = (b_fire && b_bad) || (r_fire && r_bad) || tmo_abort;

`ifdef SELFTEST_TIMEOUT_EN
    localparam int unsigned        TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout_q;
    logic             waiting;

    assign waiting   = (state == S_WR) || (state == S_WB) || (state == S_RA) || (state == S_RD);
    assign tmo_abort = waiting && (tmo_cnt == TMO_LAST) && !(wr_done || b_fire || ar_fire || r_fire);
    assign timeout   = timeout_q;

    // Watchdog restarts on every state change so each transaction gets a full budget
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_next != state) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TMO_LAST) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (start_accept) begin
                timeout_q <= 1'b0;
            end else if (tmo_abort) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_abort = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_accept) state_next = S_WR;
            S_WR:    if (wr_done) state_next = S_WB;
            S_WB:    if (b_fire) state_next = S_RA;
            S_RA:    if (ar_fire) state_next = S_RD;
            S_RD:    if (r_fire) state_next = S_NEXT;
            S_NEXT:  state_next = (idx == LAST_IDX) ? S_DONE : S_WR;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (tmo_abort) state_next = S_DONE;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= S_IDLE;
            idx           <= '0;
            addr          <= '0;
            pattern       <= '0;
            aw_valid      <= 1'b0;
            w_valid       <= 1'b0;
            aw_ok         <= 1'b0;
            w_ok          <= 1'b0;
            done          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            state <= state_next;

            if (start_accept) begin
                idx           <= '0;
                addr          <= BASE_ADDR;
                pattern       <= PAT_SEED;
                aw_ok         <= 1'b0;
                w_ok          <= 1'b0;
                done          <= 1'b0;
                err_count     <= '0;
                first_err_idx <= '0;
            end

            if (state == S_NEXT && idx != LAST_IDX) begin
                idx     <= idx + 8'd1;
                addr    <= addr + ADDR_STRIDE;
                pattern <= pattern + PAT_STEP;
                aw_ok   <= 1'b0;
                w_ok    <= 1'b0;
            end

            // AW and W are raised one cycle into WR and each retire on their own handshake
            if (state == S_WR) begin
                if (tmo_abort) begin
                    aw_valid <= 1'b0;
                    w_valid  <= 1'b0;
                end else begin
                    if (aw_fire) begin
                        aw_valid <= 1'b0;
                        aw_ok    <= 1'b1;
                    end else if (!aw_valid && !aw_ok) begin
                        aw_valid <= 1'b1;
                    end
                    if (w_fire) begin
                        w_valid <= 1'b0;
                        w_ok    <= 1'b1;
                    end else if (!w_valid && !w_ok) begin
                        w_valid <= 1'b1;
                    end
                end
            end

            if (state_next == S_DONE && state != S_DONE) begin
                done <= 1'b1;
            end

            if (log_err) begin
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                if (err_count == 8'd0) first_err_idx <= idx;
            end
        end
    end

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign pass = done && (err_count == 8'd0) && !timeout;

    assign m_axi.awaddr  = addr;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = aw_valid;
    assign m_axi.wdata   = pattern;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = w_valid;
    assign m_axi.bready  = (state == S_WB);
    assign m_axi.araddr  = addr;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = (state == S_RA);
    assign m_axi.rready  = (state == S_RD);
endmodule

// File: tb/tb_axi_lite_reg_selftest.sv
// Directed bench for axi_lite_reg_selftest: memory-like slave with error, stall and stuck-bit knobs.
// The watchdog section follows SELFTEST_TIMEOUT_EN the same way as the design.
module tb_axi_lite_reg_selftest;
    logic       ACLK = 1'b0;
    logic       ARESETN;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic       timeout;
    logic [7:0] err_count;
    logic [7:0] first_err_idx;

    int n_checks = 0;
    int n_fail   = 0;

    axi_lite_reg_selftest_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_axi ();

    axi_lite_reg_selftest #(.TIMEOUT_CYCLES(16)) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .timeout       (timeout),
        .m_axi         (m_axi)
    );

    always #5 ACLK = ~ACLK;

    // Slave knobs, written only by the stimulus process
    int   aw_delay      = 0;
    int   w_delay       = 0;
    int   stuck_idx     = -1;
    int   bresp_err_idx = -1;
    int   rresp_err_idx = -1;
    logic ar_block      = 1'b0;

    int          aw_wait;
    int          w_wait;
    logic        got_aw;
    logic        got_w;
    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [31:0] mem [8];
    logic [31:0] wlog_addr [64];
    int          aw_hs     = 0;
    int          w_hs      = 0;
    int          stab_viol = 0;
    logic        aw_stall;
    logic        w_stall;
    logic        ar_stall;
    logic [31:0] aw_prev;
    logic [31:0] w_prev;
    logic [31:0] ar_prev;

    logic        aw_fire;
    logic        w_fire;
    logic        ar_fire;
    logic [31:0] cur_waddr;
    logic [31:0] cur_wdata;
    logic [2:0]  widx;
    logic [2:0]  ridx;

    assign m_axi.awready = m_axi.awvalid && (aw_wait == aw_delay);
    assign m_axi.wready  = m_axi.wvalid && (w_wait == w_delay);
    assign m_axi.arready = m_axi.arvalid && !ar_block;
    assign aw_fire   = m_axi.awvalid && m_axi.awready;
    assign w_fire    = m_axi.wvalid && m_axi.wready;
    assign ar_fire   = m_axi.arvalid && m_axi.arready;
    assign cur_waddr = got_aw ? aw_addr_q : m_axi.awaddr;
    assign cur_wdata = got_w ? w_data_q : m_axi.wdata;
    assign widx      = cur_waddr[4:2];
    assign ridx      = m_axi.araddr[4:2];

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_wait      <= 0;
            w_wait       <= 0;
            got_aw       <= 1'b0;
            got_w        <= 1'b0;
            m_axi.bvalid <= 1'b0;
            m_axi.bresp  <= 2'b00;
            m_axi.rvalid <= 1'b0;
            m_axi.rdata  <= '0;
            m_axi.rresp  <= 2'b00;
            aw_stall     <= 1'b0;
            w_stall      <= 1'b0;
            ar_stall     <= 1'b0;
        end else begin
            if (aw_fire) begin
                got_aw                <= 1'b1;
                aw_addr_q             <= m_axi.awaddr;
                aw_wait               <= 0;
                wlog_addr[aw_hs % 64] <= m_axi.awaddr;
                aw_hs                 <= aw_hs + 1;
            end else if (m_axi.awvalid) begin
                aw_wait <= aw_wait + 1;
            end
            if (w_fire) begin
                got_w    <= 1'b1;
                w_data_q <= m_axi.wdata;
                w_wait   <= 0;
                w_hs     <= w_hs + 1;
            end else if (m_axi.wvalid) begin
                w_wait <= w_wait + 1;
            end
            if ((got_aw || aw_fire) && (got_w || w_fire)) begin
                mem[widx]    <= (int'(widx) == stuck_idx) ? (cur_wdata & ~32'h1) : cur_wdata;
                m_axi.bresp  <= (int'(widx) == bresp_err_idx) ? 2'b10 : 2'b00;
                m_axi.bvalid <= 1'b1;
                got_aw       <= 1'b0;
                got_w        <= 1'b0;
            end else if (m_axi.bvalid && m_axi.bready) begin
                m_axi.bvalid <= 1'b0;
            end
            if (ar_fire) begin
                m_axi.rvalid <= 1'b1;
                m_axi.rdata  <= mem[ridx];
                m_axi.rresp  <= (int'(ridx) == rresp_err_idx) ? 2'b10 : 2'b00;
            end else if (m_axi.rvalid && m_axi.rready) begin
                m_axi.rvalid <= 1'b0;
            end
            aw_stall <= m_axi.awvalid && !m_axi.awready;
            w_stall  <= m_axi.wvalid && !m_axi.wready;
            ar_stall <= m_axi.arvalid && !m_axi.arready;
            aw_prev  <= m_axi.awaddr;
            w_prev   <= m_axi.wdata;
            ar_prev  <= m_axi.araddr;
            if ((aw_stall && (!m_axi.awvalid || m_axi.awaddr != aw_prev)) ||
                (w_stall && (!m_axi.wvalid || m_axi.wdata != w_prev)) ||
                (ar_stall && (!m_axi.arvalid || m_axi.araddr != ar_prev))) begin
                stab_viol <= stab_viol + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One start pulse, then wait (bounded) for done; cycles counts edges after the accepting edge
    task automatic applyStimulus(input int budget, output int cycles, output logic aw_n,
                                 output logic aw_n1, output logic busy_n1);
        repeat (2) @(negedge ACLK);
        start = 1'b1;
        @(posedge ACLK);
        #1;
        start  = 1'b0;
        aw_n   = m_axi.awvalid;
        cycles = 0;
        @(posedge ACLK);
        #1;
        aw_n1   = m_axi.awvalid;
        busy_n1 = busy;
        cycles  = 1;
        while (!done && cycles < budget) begin
            @(posedge ACLK);
            #1;
            cycles++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_watchdog observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    int   cyc;
    int   cnt;
    int   wbase;
    int   aw0;
    int   w0;
    logic an;
    logic an1;
    logic bn1;

    initial begin
        start   = 1'b0;
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_pass", pass, 1'b0);
        checkOutput("rst_err_count", err_count, 8'd0);
        checkOutput("rst_first_err", first_err_idx, 8'd0);
        checkOutput("rst_timeout", timeout, 1'b0);
        checkOutput("rst_valids", {m_axi.awvalid, m_axi.wvalid, m_axi.arvalid}, 3'b000);
        checkOutput("rst_readys", {m_axi.bready, m_axi.rready}, 2'b00);
        @(negedge ACLK);
        ARESETN = 1'b1;

        $display("[TB] run 1: zero-wait memory slave");
        wbase = aw_hs;
        aw0   = aw_hs;
        w0    = w_hs;
        applyStimulus(200, cyc, an, an1, bn1);
        checkOutput("awvalid_after_accept_edge", an, 1'b0);
        checkOutput("awvalid_one_edge_later", an1, 1'b1);
        checkOutput("busy_one_edge_later", bn1, 1'b1);
        checkOutput("run1_cycles", 64'(cyc), 64'd24);
        checkOutput("run1_done", done, 1'b1);
        checkOutput("run1_pass", pass, 1'b1);
        checkOutput("run1_err_count", err_count, 8'd0);
        checkOutput("run1_busy", busy, 1'b0);
        checkOutput("run1_aw_handshakes", 64'(aw_hs - aw0), 64'd4);
        checkOutput("run1_w_handshakes", 64'(w_hs - w0), 64'd4);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("run1_wr_addr%0d", k), wlog_addr[(wbase + k) % 64], 64'(k * 4));
        end
        checkOutput("run1_mem0", mem[0], 32'h0101FFFF);
        checkOutput("run1_mem1", mem[1], 32'h01020000);
        checkOutput("run1_mem2", mem[2], 32'h01020001);
        checkOutput("run1_mem3", mem[3], 32'h01020002);
        checkOutput("prot_strb", {m_axi.awprot, m_axi.arprot, m_axi.wstrb}, {3'b000, 3'b000, 4'hF});
        repeat (5) @(posedge ACLK);
        #1;
        checkOutput("done_held_in_idle", done, 1'b1);
        checkOutput("pass_held_in_idle", pass, 1'b1);

        $display("[TB] run 2: bit 0 stuck low on register 2");
        stuck_idx = 2;
        applyStimulus(200, cyc, an, an1, bn1);
        stuck_idx = -1;
        checkOutput("stuck_done", done, 1'b1);
        checkOutput("stuck_err_count", err_count, 8'd1);
        checkOutput("stuck_first_err", first_err_idx, 8'd2);
        checkOutput("stuck_pass", pass, 1'b0);

        $display("[TB] run 3: AWREADY late, then WREADY late");
        aw_delay = 3;
        aw0      = aw_hs;
        w0       = w_hs;
        applyStimulus(300, cyc, an, an1, bn1);
        checkOutput("awslow_cycles", 64'(cyc), 64'd36);
        checkOutput("awslow_pass", pass, 1'b1);
        checkOutput("awslow_aw_handshakes", 64'(aw_hs - aw0), 64'd4);
        checkOutput("awslow_w_handshakes", 64'(w_hs - w0), 64'd4);
        aw_delay = 0;
        w_delay  = 3;
        aw0      = aw_hs;
        w0       = w_hs;
        applyStimulus(300, cyc, an, an1, bn1);
        w_delay = 0;
        checkOutput("wslow_cycles", 64'(cyc), 64'd36);
        checkOutput("wslow_pass", pass, 1'b1);
        checkOutput("wslow_aw_handshakes", 64'(aw_hs - aw0), 64'd4);
        checkOutput("wslow_w_handshakes", 64'(w_hs - w0), 64'd4);
        checkOutput("valid_stability", 64'(stab_viol), 64'd0);

        $display("[TB] run 4: SLVERR on BRESP idx 1 and RRESP idx 3");
        bresp_err_idx = 1;
        rresp_err_idx = 3;
        applyStimulus(200, cyc, an, an1, bn1);
        bresp_err_idx = -1;
        rresp_err_idx = -1;
        checkOutput("resp_err_count", err_count, 8'd2);
        checkOutput("resp_first_err", first_err_idx, 8'd1);
        checkOutput("resp_pass", pass, 1'b0);

        $display("[TB] run 5: bad RRESP and data mismatch on the same register");
        stuck_idx     = 0;
        rresp_err_idx = 0;
        applyStimulus(200, cyc, an, an1, bn1);
        stuck_idx     = -1;
        rresp_err_idx = -1;
        checkOutput("double_err_count", err_count, 8'd1);
        checkOutput("double_first_err", first_err_idx, 8'd0);
        checkOutput("double_pass", pass, 1'b0);

        $display("[TB] run 6: reset pulsed during WB of idx 2");
        rresp_err_idx = 1;
        repeat (2) @(negedge ACLK);
        start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        cnt   = 0;
        while (!(m_axi.bready && m_axi.awaddr == 32'h8) && cnt < 200) begin
            @(posedge ACLK);
            #1;
            cnt++;
        end
        checkOutput("reached_wb_idx2", {m_axi.bready, m_axi.awaddr}, {1'b1, 32'h8});
        checkOutput("pre_reset_err_count", err_count, 8'd1);
        checkOutput("pre_reset_first_err", first_err_idx, 8'd1);
        @(negedge ACLK);
        ARESETN = 1'b0;
        #1;
        checkOutput("midrst_readys", {m_axi.bready, m_axi.rready}, 2'b00);
        checkOutput("midrst_valids", {m_axi.awvalid, m_axi.wvalid, m_axi.arvalid}, 3'b000);
        checkOutput("midrst_status", {busy, done, pass, timeout}, 4'b0000);
        checkOutput("midrst_err_count", err_count, 8'd0);
        checkOutput("midrst_first_err", first_err_idx, 8'd0);
        rresp_err_idx = -1;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        wbase = aw_hs;
        applyStimulus(200, cyc, an, an1, bn1);
        checkOutput("postrst_cycles", 64'(cyc), 64'd24);
        checkOutput("postrst_pass", pass, 1'b1);
        checkOutput("postrst_first_addr", wlog_addr[wbase % 64], 32'h0);

        $display("[TB] run 7: ARREADY withheld at idx 0");
        ar_block = 1'b1;
        repeat (2) @(negedge ACLK);
        start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        cnt   = 0;
        while (!m_axi.arvalid && cnt < 100) begin
            @(posedge ACLK);
            #1;
            cnt++;
        end
        checkOutput("arvalid_reached", m_axi.arvalid, 1'b1);
`ifdef SELFTEST_TIMEOUT_EN
        cnt = 0;
        while (m_axi.arvalid && cnt < 100) begin
            @(posedge ACLK);
            #1;
            cnt++;
        end
        ar_block = 1'b0;
        checkOutput("tmo_arvalid_cycles", 64'(cnt), 64'd16);
        checkOutput("tmo_timeout", timeout, 1'b1);
        checkOutput("tmo_done", done, 1'b1);
        checkOutput("tmo_pass", pass, 1'b0);
        checkOutput("tmo_err_count", err_count, 8'd1);
        checkOutput("tmo_first_err", first_err_idx, 8'd0);
`else
        repeat (40) @(posedge ACLK);
        #1;
        checkOutput("nowd_arvalid_held", m_axi.arvalid, 1'b1);
        checkOutput("nowd_busy", busy, 1'b1);
        checkOutput("nowd_timeout", timeout, 1'b0);
        ar_block = 1'b0;
        cnt      = 0;
        while (!done && cnt < 200) begin
            @(posedge ACLK);
            #1;
            cnt++;
        end
        checkOutput("nowd_done", done, 1'b1);
        checkOutput("nowd_pass", pass, 1'b1);
`endif

        $display("[TB] run 8: clean run after the stall");
        applyStimulus(200, cyc, an, an1, bn1);
        checkOutput("final_cycles", 64'(cyc), 64'd24);
        checkOutput("final_pass", pass, 1'b1);
        checkOutput("final_timeout", timeout, 1'b0);
        checkOutput("final_err_count", err_count, 8'd0);
        checkOutput("final_stability", 64'(stab_viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
